fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised operand-forwarding and load-use hazard unit for the RV32 pipeline's decode/issue point.
- Tracks destination-register info for up to DEPTH in-flight instructions older than the issuing one.
- Produces registered per-operand forward-distance selects that arrive aligned with the consumer entering stage 1, plus a combinational stall that holds fetch.
- Adds configurable load latency, flush depth, a downstream freeze and a saturating stall counter.

Parameters:
DEPTH, 2, in-flight stages tracked and forwardable (stage 1 = youngest); DEPTH >= 1
LOAD_LAT, 1, bubbles needed between a load and a dependent consumer; 0 <= LOAD_LAT < DEPTH
FLUSH_STAGES, 1, youngest stages cleared by flush; 0..DEPTH
CNT_W, 16, stall counter width
SEL_W, $clog2(DEPTH+1), forward select width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  issuing instruction present
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_use_rs1  in  1  instruction reads rs1
in_use_rs2  in  1  instruction reads rs2
in_rd  in  5  destination register
in_rd_wen  in  1  instruction writes rd
in_is_load  in  1  instruction is a load
flush  in  1  kill issuing instruction and youngest FLUSH_STAGES stages
pipe_hold  in  1  downstream freeze; whole unit holds
stall  out  1  load-use hazard; fetch must hold the issuing instruction
fwd_sel_a  out  SEL_W  rs1 source: 0 = regfile, d = result of producer d stages older
fwd_sel_b  out  SEL_W  rs2 source, same encoding
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset: all stage entries invalid; fwd_sel_a = fwd_sel_b = 0; stall_count = 0. The stall output evaluates to 0 because no entry is valid.
- Entry contents: valid, rd, rd_wen, is_load.
- An entry matches a source when it is valid, rd_wen = 1, rd = rs, and rs != 0. x0 never matches.
- Per used source, select the lowest-index matching stage s. The youngest producer always wins.
- The match at s is ready if it is not a load, or if it is a load and s > LOAD_LAT.
  - Ready match: next select = s.
  - No match or source unused: next select = 0.
  - Unready match: hazard.
- stall = in_valid & hazard(rs1 or rs2) & ~flush & ~pipe_hold. This output is combinational.
- Advance, when pipe_hold = 0 and flush = 0:
  - Stage k+1 takes stage k for k = 1..DEPTH-1. Stage DEPTH drops off; the regfile owns that value from then on.
  - If stall = 1: stage 1 becomes a bubble and select regs load 0.
  - Otherwise: stage 1 takes the issuing fields, valid = in_valid, and select regs load the computed selects.
- Flush (pipe_hold ignored):
  - Shift as above.
  - Stage 1 becomes a bubble and select regs load 0.
  - Stages 2..FLUSH_STAGES+1 (post-shift, i.e. the former stages 1..FLUSH_STAGES) are invalidated.
- pipe_hold = 1 without flush: stages, select regs and stall_count all hold.
- stall_count increments by 1 on each cycle where stall = 1 and saturates at all-ones.
- Latency: select is registered 1 cycle after issue. A load consumer sees exactly LOAD_LAT stall cycles when the load is directly ahead of it.
- Simultaneous events:
  - flush overrides stall and pipe_hold.
  - Both operands hazardous gives a single stall.
  - rs1 = rs2 gives both selects identical.
- Reset asserted mid-operation discards all entries within one cycle.

Test Plan:
- ALU producer: add x5 then sub x6,x5,x5 back-to-back -> no stall; fwd_sel_a = fwd_sel_b = 1 in the cycle after issue.
- Load-use, LOAD_LAT=1, DEPTH=2: lw x7 then add x8,x7,x1 -> stall = 1 for one cycle with stall_count = 1; then fwd_sel_a = 2 and fwd_sel_b = 0.
- LOAD_LAT=2, DEPTH=3: same sequence -> stall for two cycles; then fwd_sel_a = 3 and stall_count = 2.
- Priority and x0: writes to x9 at distances 2 and 1, consumer reads x9 -> select = 1. Consumer reading x0 after a write to x0 -> select = 0 and no stall.
- Flush during stall: a load-use stall is active and flush = 1 -> stall = 0; the next cycle's selects = 0; stages 1..FLUSH_STAGES are invalid, so a following dependent instruction gets select 0.
- pipe_hold: assert hold for 3 cycles during a load-use hazard -> stall = 0, stages, selects and stall_count are frozen; after release, behaviour resumes as in the load-use case. Counter preloaded near max -> saturates at 0xFFFF.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding and load-use hazard unit for the RV32 decode/issue point.
// Keeps the destination info of up to DEPTH older in-flight instructions.
// For each used source it returns a registered forward distance (0 = regfile).
// It also raises a combinational stall when the nearest producer is a load
// that cannot deliver its result in time.
module fwd_hazard_unit #(
    parameter int DEPTH        = 2,
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_STAGES = 1,
    parameter int CNT_W        = 16,
    localparam int SEL_W       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic             in_use_rs1,
    input  logic             in_use_rs2,
    input  logic [4:0]       in_rd,
    input  logic             in_rd_wen,
    input  logic             in_is_load,
    input  logic             flush,
    input  logic             pipe_hold,
    output logic             stall,
    output logic [SEL_W-1:0] fwd_sel_a,
    output logic [SEL_W-1:0] fwd_sel_b,
    output logic [CNT_W-1:0] stall_count
);

    // In-flight producer tracking, index 1 = youngest.
    logic [DEPTH:1]   r_stg_vld;
    logic [DEPTH:1]   r_stg_wen;
    logic [DEPTH:1]   r_stg_ld;
    logic [4:0]       r_stg_rd [1:DEPTH];

    // Selects registered so they line up with the consumer entering stage 1.
    logic [SEL_W-1:0] r_sel_a_p1;
    logic [SEL_W-1:0] r_sel_b_p1;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [SEL_W:0]   w_res_a;
    logic [SEL_W:0]   w_res_b;
    logic             w_hazard;
    logic             w_stall;
    logic             w_advance;

    // Count up, sticking at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Result is {hazard, select}. The scan runs from the oldest stage to the
    // youngest, so the youngest matching producer is the one that remains.
    // x0 is never forwarded.
    function automatic logic [SEL_W:0] resolve(input logic [4:0] rs, input logic use_rs);
        logic [SEL_W:0] res;
        res = '0;
        if (use_rs && rs != 5'd0) begin
            for (int s = DEPTH; s >= 1; s--) begin
                if (r_stg_vld[s] && r_stg_wen[s] && r_stg_rd[s] == rs) begin
                    if (r_stg_ld[s] && s <= LOAD_LAT)
                        res = {1'b1, {SEL_W{1'b0}}};
                    else
                        res = {1'b0, SEL_W'(s)};
                end
            end
        end
        return res;
    endfunction

    // Resolve both sources against the tracked stages and form the stall.
    always_comb begin
        w_res_a   = resolve(in_rs1, in_use_rs1);
        w_res_b   = resolve(in_rs2, in_use_rs2);
        w_hazard  = in_valid & (w_res_a[SEL_W] | w_res_b[SEL_W]);
        w_stall   = w_hazard & ~flush & ~pipe_hold;
        w_advance = flush | ~pipe_hold;
    end

    // Control state: stage valids, select registers and the stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stg_vld   <= '0;
            r_sel_a_p1  <= '0;
            r_sel_b_p1  <= '0;
            r_stall_cnt <= '0;
        end else if (w_advance) begin
            for (int k = DEPTH; k >= 2; k--)
                r_stg_vld[k] <= r_stg_vld[k-1] & ~(flush && (k - 1) <= FLUSH_STAGES);
            if (flush || w_stall) begin
                r_stg_vld[1] <= 1'b0;
                r_sel_a_p1   <= '0;
                r_sel_b_p1   <= '0;
            end else begin
                r_stg_vld[1] <= in_valid;
                r_sel_a_p1   <= in_valid ? w_res_a[SEL_W-1:0] : '0;
                r_sel_b_p1   <= in_valid ? w_res_b[SEL_W-1:0] : '0;
            end
            if (w_stall)
                r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

    // Producer payload shifts with the valids and is qualified by them.
    always_ff @(posedge clk) begin
        if (w_advance) begin
            for (int k = DEPTH; k >= 2; k--) begin
                r_stg_rd[k]  <= r_stg_rd[k-1];
                r_stg_wen[k] <= r_stg_wen[k-1];
                r_stg_ld[k]  <= r_stg_ld[k-1];
            end
            r_stg_rd[1]  <= in_rd;
            r_stg_wen[1] <= in_rd_wen;
            r_stg_ld[1]  <= in_is_load;
        end
    end

    assign stall       = w_stall;
    assign fwd_sel_a   = r_sel_a_p1;
    assign fwd_sel_b   = r_sel_b_p1;
    assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit. Two instances share one stimulus stream:
//   A: DEPTH=2, LOAD_LAT=1, FLUSH_STAGES=1, CNT_W=16
//   B: DEPTH=3, LOAD_LAT=2, FLUSH_STAGES=2, CNT_W=4 (small counter to reach saturation)
// The reference model keeps, per instance, a list of in-flight instructions by distance.
module tb_fwd_hazard_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, in_use_rs1, in_use_rs2, in_rd_wen, in_is_load, flush, pipe_hold;
    logic [4:0] in_rs1, in_rs2, in_rd;

    logic        a_stall, b_stall;
    logic [1:0]  a_fa, a_fb, b_fa, b_fb;
    logic [15:0] a_cnt;
    logic [3:0]  b_cnt;

    fwd_hazard_unit #(.DEPTH(2), .LOAD_LAT(1), .FLUSH_STAGES(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
        .in_is_load(in_is_load), .flush(flush), .pipe_hold(pipe_hold), .stall(a_stall),
        .fwd_sel_a(a_fa), .fwd_sel_b(a_fb), .stall_count(a_cnt));

    fwd_hazard_unit #(.DEPTH(3), .LOAD_LAT(2), .FLUSH_STAGES(2), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
        .in_is_load(in_is_load), .flush(flush), .pipe_hold(pipe_hold), .stall(b_stall),
        .fwd_sel_a(b_fa), .fwd_sel_b(b_fb), .stall_count(b_cnt));

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    typedef struct packed { bit v; bit [4:0] rd; bit wen; bit ld; } ent_t;
    ent_t m [2][1:3];
    int   dep  [2] = '{2, 3};
    int   lat  [2] = '{1, 2};
    int   fl   [2] = '{1, 2};
    int   cmax [2] = '{65535, 15};
    int   e_sa [2];
    int   e_sb [2];
    int   e_cnt[2];

    // Nearest producer of rs at distance 1..depth; hazard if it is a load too close.
    function automatic void lookup(input int d, input logic [4:0] rs, input logic use_r,
                                   output int sel, output bit haz);
        bit found;
        found = 0; sel = 0; haz = 0;
        if (use_r && rs != 5'd0)
            for (int s = 1; s <= dep[d]; s++)
                if (!found && m[d][s].v && m[d][s].wen && m[d][s].rd == rs) begin
                    found = 1;
                    if (m[d][s].ld && s <= lat[d]) haz = 1;
                    else sel = s;
                end
    endfunction

    function automatic bit m_stall(input int d);
        int s1, s2; bit h1, h2;
        lookup(d, in_rs1, in_use_rs1, s1, h1);
        lookup(d, in_rs2, in_use_rs2, s2, h2);
        return in_valid && (h1 || h2) && !flush && !pipe_hold;
    endfunction

    task automatic m_update();
        for (int d = 0; d < 2; d++) begin
            int s1, s2; bit h1, h2, st;
            lookup(d, in_rs1, in_use_rs1, s1, h1);
            lookup(d, in_rs2, in_use_rs2, s2, h2);
            st = m_stall(d);
            if (rst) begin
                for (int s = 1; s <= 3; s++) m[d][s] = '0;
                e_sa[d] = 0; e_sb[d] = 0; e_cnt[d] = 0;
            end else if (flush || !pipe_hold) begin
                for (int s = dep[d]; s >= 2; s--) m[d][s] = m[d][s-1];
                m[d][1] = '0;
                if (flush) begin
                    for (int s = 2; s <= fl[d] + 1 && s <= dep[d]; s++) m[d][s].v = 0;
                    e_sa[d] = 0; e_sb[d] = 0;
                end else if (st) begin
                    e_sa[d] = 0; e_sb[d] = 0;
                    if (e_cnt[d] < cmax[d]) e_cnt[d]++;
                end else begin
                    m[d][1].v = in_valid; m[d][1].rd = in_rd;
                    m[d][1].wen = in_rd_wen; m[d][1].ld = in_is_load;
                    e_sa[d] = in_valid ? s1 : 0;
                    e_sb[d] = in_valid ? s2 : 0;
                end
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic set_ins(input logic v, input logic [4:0] r1, input logic u1,
                           input logic [4:0] r2, input logic u2,
                           input logic [4:0] rd, input logic wen, input logic ld);
        in_valid = v; in_rs1 = r1; in_use_rs1 = u1; in_rs2 = r2; in_use_rs2 = u2;
        in_rd = rd; in_rd_wen = wen; in_is_load = ld;
    endtask

    task automatic idle(input int n);
        set_ins(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1; flush = 0; pipe_hold = 0;
        set_ins(1, 7, 1, 7, 1, 3, 1, 1);
        tick(); tick();
        total++; if (a_fa !== 2'd0 || a_fb !== 2'd0) begin bad++; $display("FAIL reset_sel_a: got %0d/%0d want 0/0", a_fa, a_fb); end
        total++; if (b_fa !== 2'd0 || b_fb !== 2'd0) begin bad++; $display("FAIL reset_sel_b: got %0d/%0d want 0/0", b_fa, b_fb); end
        total++; if (a_cnt !== 16'd0 || b_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", a_cnt, b_cnt); end
        rst = 0;
        set_ins(1, 7, 1, 7, 1, 8, 1, 0); #1;
        total++; if (a_stall !== 1'b0 || b_stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %0b/%0b want 0/0", a_stall, b_stall); end
        idle(3);
    endtask

    task automatic test_alu_fwd();
        set_ins(1, 0, 0, 0, 0, 5, 1, 0); tick();
        set_ins(1, 5, 1, 5, 1, 6, 1, 0); #1;
        total++; if (a_stall !== 1'b0 || b_stall !== 1'b0) begin bad++; $display("FAIL alu_stall: got %0b/%0b want 0/0", a_stall, b_stall); end
        tick();
        total++; if (a_fa !== 2'd1 || a_fb !== 2'd1) begin bad++; $display("FAIL alu_sel_a: got %0d/%0d want 1/1", a_fa, a_fb); end
        total++; if (b_fa !== 2'd1 || b_fb !== 2'd1) begin bad++; $display("FAIL alu_sel_b: got %0d/%0d want 1/1", b_fa, b_fb); end
        idle(3);
    endtask

    task automatic test_load_use();
        set_ins(1, 0, 0, 0, 0, 7, 1, 1); tick();
        set_ins(1, 7, 1, 1, 1, 8, 1, 0); #1;
        total++; if (a_stall !== 1'b1 || b_stall !== 1'b1) begin bad++; $display("FAIL lu_stall1: got %0b/%0b want 1/1", a_stall, b_stall); end
        tick();
        total++; if (a_cnt !== 16'd1 || b_cnt !== 4'd1) begin bad++; $display("FAIL lu_cnt1: got %0d/%0d want 1/1", a_cnt, b_cnt); end
        total++; if (a_fa !== 2'd0) begin bad++; $display("FAIL lu_bubble_sel: got %0d want 0", a_fa); end
        #1;
        total++; if (a_stall !== 1'b0 || b_stall !== 1'b1) begin bad++; $display("FAIL lu_stall2: got %0b/%0b want 0/1", a_stall, b_stall); end
        tick();
        total++; if (a_fa !== 2'd2 || a_fb !== 2'd0) begin bad++; $display("FAIL lu_sel_a: got %0d/%0d want 2/0", a_fa, a_fb); end
        total++; if (b_cnt !== 4'd2) begin bad++; $display("FAIL lu_cnt_b: got %0d want 2", b_cnt); end
        #1;
        total++; if (b_stall !== 1'b0) begin bad++; $display("FAIL lu_stall3_b: got %0b want 0", b_stall); end
        tick();
        total++; if (b_fa !== 2'd3 || b_fb !== 2'd0) begin bad++; $display("FAIL lu_sel_b: got %0d/%0d want 3/0", b_fa, b_fb); end
        total++; if (a_cnt !== 16'd1 || b_cnt !== 4'd2) begin bad++; $display("FAIL lu_cnt_end: got %0d/%0d want 1/2", a_cnt, b_cnt); end
        idle(3);
    endtask

    task automatic test_priority_x0();
        set_ins(1, 0, 0, 0, 0, 9, 1, 0); tick();
        set_ins(1, 0, 0, 0, 0, 9, 1, 0); tick();
        set_ins(1, 9, 1, 0, 1, 10, 1, 0); #1;
        total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL prio_stall: got %0b want 0", a_stall); end
        tick();
        total++; if (a_fa !== 2'd1 || a_fb !== 2'd0) begin bad++; $display("FAIL prio_sel_a: got %0d/%0d want 1/0", a_fa, a_fb); end
        total++; if (b_fa !== 2'd1) begin bad++; $display("FAIL prio_sel_b: got %0d want 1", b_fa); end
        set_ins(1, 0, 0, 0, 0, 0, 1, 1); tick();
        set_ins(1, 0, 1, 0, 1, 11, 1, 0); #1;
        total++; if (a_stall !== 1'b0 || b_stall !== 1'b0) begin bad++; $display("FAIL x0_stall: got %0b/%0b want 0/0", a_stall, b_stall); end
        tick();
        total++; if (a_fa !== 2'd0 || a_fb !== 2'd0 || b_fa !== 2'd0) begin bad++; $display("FAIL x0_sel: got %0d/%0d/%0d want 0/0/0", a_fa, a_fb, b_fa); end
        idle(3);
    endtask

    task automatic test_flush();
        set_ins(1, 0, 0, 0, 0, 9, 1, 0); tick();
        set_ins(1, 9, 1, 0, 0, 7, 1, 1); tick();
        total++; if (a_fa !== 2'd1) begin bad++; $display("FAIL fl_pre_sel: got %0d want 1", a_fa); end
        set_ins(1, 7, 1, 1, 1, 8, 1, 0); flush = 1; #1;
        total++; if (a_stall !== 1'b0 || b_stall !== 1'b0) begin bad++; $display("FAIL fl_stall: got %0b/%0b want 0/0", a_stall, b_stall); end
        tick();
        total++; if (a_fa !== 2'd0 || a_fb !== 2'd0 || b_fa !== 2'd0) begin bad++; $display("FAIL fl_sel: got %0d/%0d/%0d want 0/0/0", a_fa, a_fb, b_fa); end
        flush = 0; #1;
        total++; if (a_stall !== 1'b0 || b_stall !== 1'b0) begin bad++; $display("FAIL fl_after_stall: got %0b/%0b want 0/0", a_stall, b_stall); end
        tick();
        total++; if (a_fa !== 2'd0 || b_fa !== 2'd0) begin bad++; $display("FAIL fl_after_sel: got %0d/%0d want 0/0", a_fa, b_fa); end
        total++; if (a_cnt !== 16'd1 || b_cnt !== 4'd2) begin bad++; $display("FAIL fl_cnt: got %0d/%0d want 1/2", a_cnt, b_cnt); end
        idle(3);
    endtask

    task automatic test_hold();
        set_ins(1, 0, 0, 0, 0, 9, 1, 0); tick();
        set_ins(1, 9, 1, 0, 0, 7, 1, 1); tick();
        set_ins(1, 7, 1, 1, 1, 8, 1, 0); pipe_hold = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (a_stall !== 1'b0 || b_stall !== 1'b0) begin bad++; $display("FAIL hold_stall%0d: got %0b/%0b want 0/0", i, a_stall, b_stall); end
            tick();
            total++; if (a_fa !== 2'd1 || b_fa !== 2'd1) begin bad++; $display("FAIL hold_sel%0d: got %0d/%0d want 1/1", i, a_fa, b_fa); end
            total++; if (a_cnt !== 16'd1 || b_cnt !== 4'd2) begin bad++; $display("FAIL hold_cnt%0d: got %0d/%0d want 1/2", i, a_cnt, b_cnt); end
        end
        pipe_hold = 0; #1;
        total++; if (a_stall !== 1'b1 || b_stall !== 1'b1) begin bad++; $display("FAIL hold_rel_stall: got %0b/%0b want 1/1", a_stall, b_stall); end
        tick();
        total++; if (a_cnt !== 16'd2 || b_cnt !== 4'd3) begin bad++; $display("FAIL hold_rel_cnt: got %0d/%0d want 2/3", a_cnt, b_cnt); end
        #1;
        total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL hold_rel_stall2: got %0b want 0", a_stall); end
        tick();
        total++; if (a_fa !== 2'd2) begin bad++; $display("FAIL hold_rel_sel: got %0d want 2", a_fa); end
        idle(3);
    endtask

    task automatic test_reset_mid();
        set_ins(1, 0, 0, 0, 0, 7, 1, 1); tick();
        set_ins(1, 7, 1, 1, 1, 8, 1, 0); rst = 1; tick();
        total++; if (a_cnt !== 16'd0 || b_cnt !== 4'd0) begin bad++; $display("FAIL rmid_cnt: got %0d/%0d want 0/0", a_cnt, b_cnt); end
        rst = 0; #1;
        total++; if (a_stall !== 1'b0 || b_stall !== 1'b0) begin bad++; $display("FAIL rmid_stall: got %0b/%0b want 0/0", a_stall, b_stall); end
        tick();
        total++; if (a_fa !== 2'd0 || b_fa !== 2'd0) begin bad++; $display("FAIL rmid_sel: got %0d/%0d want 0/0", a_fa, b_fa); end
        idle(3);
    endtask

    task automatic test_saturation();
        // lw x7,(x7) repeatedly: each copy depends on the previous load.
        set_ins(1, 7, 1, 0, 0, 7, 1, 1);
        repeat (48) tick();
        total++; if (b_cnt !== 4'hF) begin bad++; $display("FAIL sat_cnt_b: got %0d want 15", b_cnt); end
        total++; if (a_cnt !== 16'(e_cnt[0])) begin bad++; $display("FAIL sat_cnt_a: got %0d want %0d", a_cnt, e_cnt[0]); end
        idle(3);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bit ea, eb;
            rst       = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 9) == 0);
            pipe_hold = ($urandom_range(0, 7) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_rs1 = 5'($urandom_range(0, 3)); in_rs2 = 5'($urandom_range(0, 3));
            in_rd  = 5'($urandom_range(0, 3));
            in_use_rs1 = in_valid & 1'($urandom_range(0, 1));
            in_use_rs2 = in_valid & 1'($urandom_range(0, 1));
            in_rd_wen  = 1'($urandom_range(0, 1));
            in_is_load = ($urandom_range(0, 2) == 0);
            #1;
            ea = m_stall(0); eb = m_stall(1);
            total++; if (a_stall !== ea) begin bad++; $display("FAIL rnd_stall_a@%0d: got %0b want %0b", i, a_stall, ea); end
            total++; if (b_stall !== eb) begin bad++; $display("FAIL rnd_stall_b@%0d: got %0b want %0b", i, b_stall, eb); end
            tick();
            total++; if (a_fa !== 2'(e_sa[0]) || a_fb !== 2'(e_sb[0])) begin bad++; $display("FAIL rnd_sel_a@%0d: got %0d/%0d want %0d/%0d", i, a_fa, a_fb, e_sa[0], e_sb[0]); end
            total++; if (b_fa !== 2'(e_sa[1]) || b_fb !== 2'(e_sb[1])) begin bad++; $display("FAIL rnd_sel_b@%0d: got %0d/%0d want %0d/%0d", i, b_fa, b_fb, e_sa[1], e_sb[1]); end
            total++; if (a_cnt !== 16'(e_cnt[0])) begin bad++; $display("FAIL rnd_cnt_a@%0d: got %0d want %0d", i, a_cnt, e_cnt[0]); end
            total++; if (b_cnt !== 4'(e_cnt[1])) begin bad++; $display("FAIL rnd_cnt_b@%0d: got %0d want %0d", i, b_cnt, e_cnt[1]); end
        end
        rst = 0; flush = 0; pipe_hold = 0;
    endtask

    initial begin
        rst = 1; flush = 0; pipe_hold = 0;
        set_ins(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_priority_x0();
        test_flush();
        test_hold();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
